dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the `mips` core's data port and `mem`, mirroring `icache` on the instruction side. Read hits return data combinationally in the request cycle. Misses stall the core while a full line is fetched from `mem` one 32-bit beat at a time. Stores update a hitting line and are always forwarded to `mem`, with the core stalled until `mem` acknowledges.

---
 rtl/dcache_if.sv | 39 +++
 rtl/dcache.sv | 197 +++++++++++++++++++
 tb/tb_dcache.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_if.sv
// Core/memory bus bundle for the data cache.
// Core side : cpu_adr, cpu_read, cpu_memwrite, cpu_dword, cpu_wdata -> cache
//             cpu_rdata, hit, stall                                  <- cache
// Memory side: mem_req, mem_adr, mem_memwrite, mem_wdata              <- cache
//             mem_rdata, mem_val, mem_wack                            -> cache
// Modport slave is the cache; modport master is the core+memory environment.
interface dcache_if #(
  parameter int unsigned N = 64
);
  logic [31:0]  cpu_adr;
  logic         cpu_read;
  logic [1:0]   cpu_memwrite;
  logic         cpu_dword;
  logic [N-1:0] cpu_wdata;
  logic [N-1:0] cpu_rdata;
  logic         hit;
  logic         stall;
  logic         mem_req;
  logic [31:0]  mem_adr;
  logic [31:0]  mem_rdata;
  logic         mem_val;
  logic [1:0]   mem_memwrite;
  logic [N-1:0] mem_wdata;
  logic         mem_wack;

  modport slave (
    input  cpu_adr, cpu_read, cpu_memwrite, cpu_dword, cpu_wdata,
    input  mem_rdata, mem_val, mem_wack,
    output cpu_rdata, hit, stall,
    output mem_req, mem_adr, mem_memwrite, mem_wdata
  );

  modport master (
    output cpu_adr, cpu_read, cpu_memwrite, cpu_dword, cpu_wdata,
    output mem_rdata, mem_val, mem_wack,
    input  cpu_rdata, hit, stall,
    input  mem_req, mem_adr, mem_memwrite, mem_wdata
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Load hits return data in the request cycle; misses fill a whole line one
// 32-bit beat at a time; stores update a hitting line and are always
// forwarded to memory while the core is stalled.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    dcache_if.slave: core request/response and memory fill/store bus
//   hitcount, misscount (only with DCACHE_STATS_EN): load hit / miss counters
// Optional feature macro: DCACHE_STATS_EN.
module dcache #(
  parameter int unsigned N          = 64,
  parameter int unsigned LINES      = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hitcount,
  output logic [31:0] misscount
`endif
);

  localparam int unsigned WSEL_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned OFF_W  = WSEL_W + 2;
  localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [31:0]         r_data [LINES][LINE_WORDS];

  logic [31:0]         r_adr;
  logic [N-1:0]        r_wdata;
  logic [1:0]          r_wr;
  logic [WSEL_W-1:0]   r_beat;

  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_fidx;
  logic [TAG_W-1:0]    w_tag;
  logic [WSEL_W-1:0]   w_wsel;
  logic [WSEL_W-1:0]   w_wlo;
  logic [WSEL_W-1:0]   w_whi;
  logic                w_idle;
  logic                w_store;
  logic                w_load;
  logic                w_match;
  logic                w_ld_hit;
  logic                w_ld_miss;
  logic                w_st_hit;
  logic                w_fill_we;
  logic                w_fill_last;
  logic [63:0]         w_rd;
  logic                w_unused;

  // Address decode of the live core request
  assign w_idx   = bus.cpu_adr[OFF_W +: IDX_W];
  assign w_tag   = bus.cpu_adr[31 -: TAG_W];
  assign w_wsel  = bus.cpu_adr[2 +: WSEL_W];
  // Doubleword pair ignores adr[2]: even word low, odd word high
  assign w_wlo   = w_wsel & ~WSEL_W'(1);
  assign w_whi   = w_wsel |  WSEL_W'(1);
  assign w_fidx  = r_adr[OFF_W +: IDX_W];

  // Request classification; a store takes precedence over a concurrent load
  assign w_idle    = (r_state == S_IDLE);
  assign w_store   = (bus.cpu_memwrite == 2'b01) || (bus.cpu_memwrite == 2'b11);
  assign w_load    = bus.cpu_read && !w_store;
  assign w_match   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_ld_hit  = w_idle && w_load && w_match;
  assign w_ld_miss = w_idle && w_load && !w_match;
  assign w_st_hit  = w_idle && w_store && w_match;

  assign w_fill_we   = (r_state == S_FILL) && bus.mem_val;
  assign w_fill_last = w_fill_we && (r_beat == WSEL_W'(LINE_WORDS - 1));

  // Load data: doubleword pair or zero-extended single word
  assign w_rd = bus.cpu_dword ? {r_data[w_idx][w_whi], r_data[w_idx][w_wlo]}
                              : {32'h0, r_data[w_idx][w_wsel]};

  assign w_unused = ^bus.cpu_adr[1:0];

  // State register
  always_ff @(posedge clk) begin : state_reg
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin : next_state
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_store)        w_state_nxt = S_WRITE;
        else if (w_ld_miss) w_state_nxt = S_FILL;
      end
      S_FILL:  if (w_fill_last)  w_state_nxt = S_IDLE;
      S_WRITE: if (bus.mem_wack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic; everything is forced low while reset is held
  always_comb begin : outputs
    bus.hit          = 1'b0;
    bus.stall        = 1'b0;
    bus.cpu_rdata    = '0;
    bus.mem_req      = 1'b0;
    bus.mem_adr      = 32'h0;
    bus.mem_memwrite = 2'b00;
    bus.mem_wdata    = '0;
    if (reset) begin
      case (r_state)
        S_IDLE: begin
          bus.hit   = w_ld_hit;
          bus.stall = w_store || w_ld_miss;
          if (w_ld_hit) bus.cpu_rdata = N'(w_rd);
        end
        S_FILL: begin
          bus.stall   = 1'b1;
          bus.mem_req = 1'b1;
          bus.mem_adr = {r_adr[31:OFF_W], r_beat, 2'b00};
        end
        S_WRITE: begin
          bus.stall        = 1'b1;
          bus.mem_memwrite = r_wr;
          bus.mem_adr      = r_adr;
          bus.mem_wdata    = r_wdata;
        end
        default: ;
      endcase
    end
  end

  // Request latches, fill beat counter and valid bits
  always_ff @(posedge clk) begin : ctrl_reg
    if (!reset) begin
      r_valid <= '0;
      r_beat  <= '0;
      r_adr   <= 32'h0;
      r_wdata <= '0;
      r_wr    <= 2'b00;
    end else begin
      if (w_idle && w_store) begin
        r_adr   <= bus.cpu_adr;
        r_wdata <= bus.cpu_wdata;
        r_wr    <= bus.cpu_memwrite;
      end else if (w_ld_miss) begin
        r_adr   <= bus.cpu_adr;
      end
      // Counter is a power of two wide, so it wraps to 0 on the last beat
      if (w_fill_we) r_beat <= r_beat + WSEL_W'(1);
      if (w_fill_last) r_valid[w_fidx] <= 1'b1;
    end
  end

  // Line storage: fill beats, tag on completion, write-through store hits
  always_ff @(posedge clk) begin : line_store
    if (reset) begin
      if (w_fill_we)   r_data[w_fidx][r_beat] <= bus.mem_rdata;
      if (w_fill_last) r_tag[w_fidx]          <= r_adr[31 -: TAG_W];
      if (w_st_hit) begin
        if (bus.cpu_memwrite == 2'b11) begin
          r_data[w_idx][w_wlo] <= bus.cpu_wdata[31:0];
          r_data[w_idx][w_whi] <= bus.cpu_wdata[63:32];
        end else begin
          r_data[w_idx][w_wsel] <= bus.cpu_wdata[31:0];
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // Load hit / miss statistics, wrapping modulo 2^32
  always_ff @(posedge clk) begin : stats_reg
    if (!reset) begin
      hitcount  <= 32'h0;
      misscount <= 32'h0;
    end else begin
      if (w_ld_hit)  hitcount  <= hitcount + 32'd1;
      if (w_ld_miss) misscount <= misscount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: the bench plays core and memory. The model
// keeps a word-addressed memory image plus line residency (valid/tag per
// index); since the cache is write-through, a resident line always mirrors
// memory, so load data is predicted from the memory image.
module tb_dcache;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  dcache_if #(.N(64)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hitcount;
  logic [31:0] misscount;
`endif

  dcache u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hitcount  (hitcount),
    .misscount (misscount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] memm [logic [31:0]];
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  int unsigned m_hits;
  int unsigned m_misses;

  function automatic logic [31:0] mw(input logic [31:0] a);
    if (memm.exists(a)) return memm[a];
    return a ^ 32'hC3A5_0F1E ^ (a << 7);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic idle_cpu();
    bus.cpu_adr      = 32'h0;
    bus.cpu_read     = 1'b0;
    bus.cpu_memwrite = 2'b00;
    bus.cpu_dword    = 1'b0;
    bus.cpu_wdata    = 64'h0;
  endtask

  task automatic scramble_cpu();
    bus.cpu_adr      = $urandom;
    bus.cpu_read     = 1'($urandom_range(0, 1));
    bus.cpu_memwrite = 2'($urandom_range(0, 3));
    bus.cpu_dword    = 1'($urandom_range(0, 1));
    bus.cpu_wdata    = {$urandom, $urandom};
  endtask

  // Load: predicts hit/miss from residency and serves the fill if needed
  task automatic do_load(input logic [31:0] a, input logic dw, input int maxgap);
    logic [63:0] exp;
    logic [31:0] base, tag, d2;
    int          idx, gap;
    bit          res;
    idx  = int'((a >> 4) & 32'hF);
    tag  = a >> 8;
    base = a & ~32'hF;
    d2   = a & ~32'h7;
    exp  = dw ? {mw(d2 + 32'd4), mw(d2)} : {32'h0, mw(a & ~32'h3)};
    res  = m_valid[idx] && (m_tag[idx] == tag);
    bus.cpu_adr = a; bus.cpu_read = 1'b1; bus.cpu_dword = dw;
    bus.cpu_memwrite = 2'b00; bus.cpu_wdata = {$urandom, $urandom};
    bus.mem_val  = 1'($urandom_range(0, 1));
    bus.mem_wack = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    @(negedge clk);
    if (res) begin
      checks++;
      if (bus.hit !== 1'b1 || bus.stall !== 1'b0 || bus.cpu_rdata !== exp || bus.mem_req !== 1'b0) begin
        failures++;
        $display("FAIL load_hit adr=%h got hit=%b stall=%b rdata=%h req=%b want hit=1 stall=0 rdata=%h req=0",
                 a, bus.hit, bus.stall, bus.cpu_rdata, bus.mem_req, exp);
      end
      m_hits++;
    end else begin
      checks++;
      if (bus.hit !== 1'b0 || bus.stall !== 1'b1 || bus.mem_req !== 1'b0) begin
        failures++;
        $display("FAIL load_miss adr=%h got hit=%b stall=%b req=%b want hit=0 stall=1 req=0",
                 a, bus.hit, bus.stall, bus.mem_req);
      end
      m_misses++;
      @(posedge clk); #1;
      bus.mem_val = 1'b0; bus.mem_wack = 1'b0;
      for (int b = 0; b < 4; b++) begin
        gap = $urandom_range(0, maxgap);
        for (int g = 0; g <= gap; g++) begin
          scramble_cpu();
          bus.mem_val   = (g == gap);
          bus.mem_rdata = (g == gap) ? mw(base + 32'(4 * b)) : $urandom;
          @(negedge clk);
          checks++;
          if (bus.mem_req !== 1'b1 || bus.stall !== 1'b1 || bus.hit !== 1'b0 ||
              bus.mem_adr !== base + 32'(4 * b)) begin
            failures++;
            $display("FAIL fill_beat adr=%h beat=%0d got req=%b stall=%b hit=%b mem_adr=%h want req=1 stall=1 hit=0 mem_adr=%h",
                     a, b, bus.mem_req, bus.stall, bus.hit, bus.mem_adr, base + 32'(4 * b));
          end
          @(posedge clk); #1;
        end
      end
      bus.mem_val = 1'b0;
      bus.cpu_adr = a; bus.cpu_read = 1'b1; bus.cpu_dword = dw; bus.cpu_memwrite = 2'b00;
      @(negedge clk);
      checks++;
      if (bus.hit !== 1'b1 || bus.stall !== 1'b0 || bus.cpu_rdata !== exp || bus.mem_req !== 1'b0) begin
        failures++;
        $display("FAIL fill_done adr=%h got hit=%b stall=%b rdata=%h req=%b want hit=1 stall=0 rdata=%h req=0",
                 a, bus.hit, bus.stall, bus.cpu_rdata, bus.mem_req, exp);
      end
      m_hits++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    @(posedge clk); #1;
    idle_cpu();
    bus.mem_val = 1'b0; bus.mem_wack = 1'b0;
  endtask

  // Store: wd WRITE cycles, mem_wack on the last; memory image updated
  task automatic do_store(input logic [31:0] a, input logic [1:0] enc,
                          input logic [63:0] d, input int wd);
    bus.cpu_adr = a; bus.cpu_memwrite = enc; bus.cpu_wdata = d;
    bus.cpu_read = 1'($urandom_range(0, 1)); bus.cpu_dword = 1'($urandom_range(0, 1));
    bus.mem_val = 1'($urandom_range(0, 1)); bus.mem_wack = 1'($urandom_range(0, 1));
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1 || bus.hit !== 1'b0 || bus.mem_memwrite !== 2'b00 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL store_issue adr=%h got stall=%b hit=%b memwrite=%b req=%b want stall=1 hit=0 memwrite=00 req=0",
               a, bus.stall, bus.hit, bus.mem_memwrite, bus.mem_req);
    end
    @(posedge clk); #1;
    for (int c = 1; c <= wd; c++) begin
      scramble_cpu();
      bus.mem_val  = 1'($urandom_range(0, 1));
      bus.mem_wack = (c == wd);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b1 || bus.mem_memwrite !== enc || bus.mem_adr !== a ||
          bus.mem_wdata !== d || bus.mem_req !== 1'b0) begin
        failures++;
        $display("FAIL store_write adr=%h cyc=%0d got stall=%b mw=%b madr=%h wdata=%h req=%b want stall=1 mw=%b madr=%h wdata=%h req=0",
                 a, c, bus.stall, bus.mem_memwrite, bus.mem_adr, bus.mem_wdata, bus.mem_req, enc, a, d);
      end
      @(posedge clk); #1;
    end
    idle_cpu();
    bus.mem_wack = 1'b0; bus.mem_val = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.mem_memwrite !== 2'b00) begin
      failures++;
      $display("FAIL store_done adr=%h got stall=%b memwrite=%b want stall=0 memwrite=00",
               a, bus.stall, bus.mem_memwrite);
    end
    if (enc == 2'b11) begin
      memm[a & ~32'h7]           = d[31:0];
      memm[(a & ~32'h7) + 32'd4] = d[63:32];
    end else begin
      memm[a & ~32'h3] = d[31:0];
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      scramble_cpu();
      bus.mem_val = 1'($urandom_range(0, 1)); bus.mem_wack = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (bus.hit !== 1'b0 || bus.stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_memwrite !== 2'b00 ||
          bus.cpu_rdata !== 64'h0 || bus.mem_adr !== 32'h0 || bus.mem_wdata !== 64'h0) begin
        failures++;
        $display("FAIL reset_outputs got hit=%b stall=%b req=%b mw=%b rdata=%h madr=%h wdata=%h want all zero",
                 bus.hit, bus.stall, bus.mem_req, bus.mem_memwrite, bus.cpu_rdata, bus.mem_adr, bus.mem_wdata);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    idle_cpu();
    bus.mem_val = 1'b0; bus.mem_wack = 1'b0;
    model_reset();
`ifdef DCACHE_STATS_EN
    checks++;
    if (hitcount !== 32'h0 || misscount !== 32'h0) begin
      failures++;
      $display("FAIL reset_stats got hit=%0d miss=%0d want 0 0", hitcount, misscount);
    end
`endif
  endtask

  task automatic test_plan_fill();
    do_load(32'h40, 1'b1, 0);
    do_load(32'h4C, 1'b0, 0);
  endtask

  task automatic test_store_hit();
    do_store(32'h48, 2'b11, 64'hAAAABBBBCCCCDDDD, 3);
    do_load(32'h48, 1'b1, 0);
    do_store(32'h44, 2'b01, 64'h1234567855AA55AA, 1);
    do_load(32'h40, 1'b1, 0);
  endtask

  task automatic test_store_miss();
    do_store(32'h1000, 2'b01, 64'h00000000DEADBEEF, 2);
    do_load(32'h1000, 1'b0, 1);
  endtask

  task automatic test_evict();
    do_load(32'h140, 1'b1, 1);
    do_load(32'h40, 1'b1, 1);
  endtask

  task automatic test_noop_encoding();
    bus.cpu_adr = 32'h40; bus.cpu_memwrite = 2'b10; bus.cpu_read = 1'b0;
    bus.cpu_wdata = {$urandom, $urandom};
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.hit !== 1'b0 || bus.mem_memwrite !== 2'b00 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL noop_enc got stall=%b hit=%b mw=%b req=%b want 0 0 00 0",
               bus.stall, bus.hit, bus.mem_memwrite, bus.mem_req);
    end
    @(posedge clk); #1;
    idle_cpu();
    do_load(32'h40, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    do_load(32'h40, 1'b0, 0);
    do_load(32'h44, 1'b0, 0);
    do_load(32'h48, 1'b1, 0);
    do_load(32'h4C, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          op;
    for (int n = 0; n < 80; n++) begin
      a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
           (32'($urandom_range(0, 3)) << 2);
      op = $urandom_range(0, 19);
      if (op < 11)      do_load(a, 1'($urandom_range(0, 1)), 2);
      else if (op < 19) do_store(a, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01,
                                 {$urandom, $urandom}, $urandom_range(1, 3));
      else              test_noop_encoding();
    end
`ifdef DCACHE_STATS_EN
    checks++;
    if (hitcount !== 32'(m_hits) || misscount !== 32'(m_misses)) begin
      failures++;
      $display("FAIL stats got hit=%0d miss=%0d want hit=%0d miss=%0d", hitcount, misscount, m_hits, m_misses);
    end
`endif
  endtask

  task automatic test_reset_midfill();
    test_reset();
    bus.cpu_adr = 32'h40; bus.cpu_read = 1'b1; bus.cpu_dword = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin
      bus.mem_val = 1'b1; bus.mem_rdata = 32'hBAD0_0000 + 32'(b);
      @(posedge clk); #1;
    end
    bus.mem_val = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL midfill_in_reset got req=%b stall=%b want 0 0", bus.mem_req, bus.stall);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cpu();
    bus.mem_val = 1'b1; bus.mem_rdata = 32'hBAD0_0002;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.hit !== 1'b0) begin
      failures++;
      $display("FAIL midfill_after_reset got req=%b stall=%b hit=%b want 0 0 0",
               bus.mem_req, bus.stall, bus.hit);
    end
    @(posedge clk); #1;
    bus.mem_val = 1'b0;
    model_reset();
`ifdef DCACHE_STATS_EN
    checks++;
    if (hitcount !== 32'h0 || misscount !== 32'h0) begin
      failures++;
      $display("FAIL midfill_stats got hit=%0d miss=%0d want 0 0", hitcount, misscount);
    end
`endif
    do_load(32'h40, 1'b1, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle_cpu();
    bus.mem_val   = 1'b0;
    bus.mem_wack  = 1'b0;
    bus.mem_rdata = 32'h0;
    memm[32'h40] = 32'h11111111;
    memm[32'h44] = 32'h22222222;
    memm[32'h48] = 32'h33333333;
    memm[32'h4C] = 32'h44444444;
    model_reset();
    #1;
    test_reset();
    test_plan_fill();
    test_store_hit();
    test_store_miss();
    test_evict();
    test_noop_encoding();
    test_back_to_back();
    test_random();
    test_reset_midfill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
